// File: rtl/l2_snoop_responder.sv
// rtl/l2_snoop_responder.sv - L2 line-fill responder with write-back store for a single L1
// Reads return a 128-bit line LATENCY cycles after acceptance; evictions write the store at any time.
module l2_snoop_responder #(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  snooper_addr,
    input  logic         snooper_read_valid,
    input  logic         eviction_wren,
    input  logic [127:0] evictable_cacheline,
    input  logic         l1_hold,
    output logic [127:0] updated_cacheline,
    output logic         cacheline_update_valid,
    output logic         busy,
    output logic         protocol_error,
    output logic [15:0]  read_count,
    output logic [15:0]  evict_count
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [3:0]          lat_cnt;
    logic [IDX_W-1:0]    req_idx;
    logic [IDX_W-1:0]    pend_idx;
    logic [127:0]        fill_line;
    logic                accept_read;
    logic                fill_load;
    logic                fill_done;
    logic                bad_read;
    logic                unused_addr;

    // Store contents survive reset; only the power-up image is zero.
    logic [127:0]        mem [0:DEPTH-1] = '{default: '0};

    assign req_idx     = snooper_addr[IDX_W+3:4];
    assign unused_addr = ^{snooper_addr[31:IDX_W+4], snooper_addr[3:0]};
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (eviction_wren) begin
            mem[req_idx] <= evictable_cacheline;
        end
    end

    // Write-first bypass so an eviction on the capture edge reaches the fill.
    assign fill_line = (eviction_wren && (req_idx == pend_idx)) ? evictable_cacheline
                                                                : mem[pend_idx];

    assign bad_read = snooper_read_valid && (eviction_wren || (state != S_IDLE));

    always_comb begin
        state_next  = state;
        accept_read = 1'b0;
        fill_load   = 1'b0;
        fill_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (snooper_read_valid && !eviction_wren) begin
                    accept_read = 1'b1;
                    state_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt == 4'd0) begin
                    fill_load  = 1'b1;
                    state_next = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (!l1_hold) begin
                    fill_done  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= S_IDLE;
            lat_cnt                <= 4'd0;
            pend_idx               <= '0;
            cacheline_update_valid <= 1'b0;
            updated_cacheline      <= '0;
            protocol_error         <= 1'b0;
            read_count             <= 16'd0;
            evict_count            <= 16'd0;
        end else begin
            state <= state_next;

            if (accept_read) begin
                lat_cnt  <= WAIT_LOAD;
                pend_idx <= req_idx;
            end else if ((state == S_WAIT) && (lat_cnt != 4'd0)) begin
                lat_cnt <= lat_cnt - 4'd1;
            end

            if (fill_load) begin
                cacheline_update_valid <= 1'b1;
                updated_cacheline      <= fill_line;
            end else if (fill_done) begin
                cacheline_update_valid <= 1'b0;
                updated_cacheline      <= '0;
            end

            if (bad_read) begin
                protocol_error <= 1'b1;
            end

            if (accept_read && (read_count != 16'hFFFF)) begin
                read_count <= read_count + 16'd1;
            end
            if (eviction_wren && (evict_count != 16'hFFFF)) begin
                evict_count <= evict_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_l2_snoop_responder.sv
// tb/tb_l2_snoop_responder.sv - directed table-driven bench for l2_snoop_responder
module tb_l2_snoop_responder;

    logic         clk;
    logic         reset;
    logic [31:0]  snooper_addr;
    logic         snooper_read_valid;
    logic         eviction_wren;
    logic [127:0] evictable_cacheline;
    logic         l1_hold;
    logic [127:0] updated_cacheline;
    logic         cacheline_update_valid;
    logic         busy;
    logic         protocol_error;
    logic [15:0]  read_count;
    logic [15:0]  evict_count;

    int checks = 0;
    int errors = 0;

    l2_snoop_responder #(.LATENCY(4), .IDX_W(10)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .snooper_addr           (snooper_addr),
        .snooper_read_valid     (snooper_read_valid),
        .eviction_wren          (eviction_wren),
        .evictable_cacheline    (evictable_cacheline),
        .l1_hold                (l1_hold),
        .updated_cacheline      (updated_cacheline),
        .cacheline_update_valid (cacheline_update_valid),
        .busy                   (busy),
        .protocol_error         (protocol_error),
        .read_count             (read_count),
        .evict_count            (evict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         rd;
        logic         ev;
        logic         hold;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic         exp_valid;
        logic [127:0] exp_data;
        logic         exp_busy;
        logic         exp_err;
        logic [15:0]  exp_rc;
        logic [15:0]  exp_ec;
    } vec_t;

    vec_t vecs[$];

    localparam logic [127:0] LD = {32'hD, 32'hC, 32'hB, 32'hA};
    localparam logic [127:0] LE = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] LF = 128'hF0F0_0F0F_1234_5678_9ABC_DEF0_CAFE_BEEF;
    localparam logic [127:0] LFF = 128'hFF;
    localparam logic [127:0] LH = 128'hAAAA_5555_0000_FFFF_DEAD_BEEF_0BAD_F00D;
    localparam logic [127:0] LG = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    task automatic row(input logic rst, rd, ev, hold, input logic [31:0] addr,
                       input logic [127:0] wd, input logic v, input logic [127:0] d,
                       input logic b, e, input logic [15:0] rc, ec);
        vec_t r;
        r.rst = rst; r.rd = rd; r.ev = ev; r.hold = hold; r.addr = addr; r.wdata = wd;
        r.exp_valid = v; r.exp_data = d; r.exp_busy = b; r.exp_err = e;
        r.exp_rc = rc; r.exp_ec = ec;
        vecs.push_back(r);
    endtask

    task automatic idle(input int n, input logic hold, input logic v, input logic [127:0] d,
                        input logic b, e, input logic [15:0] rc, ec);
        for (int k = 0; k < n; k++) row(0, 0, 0, hold, 32'h0, '0, v, d, b, e, rc, ec);
    endtask

    task automatic chk(input int idx, input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row %0d %s: got %0h expected %0h", idx, nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, rd, ev, hold, input logic [31:0] addr, input logic [127:0] wd);
        reset = rst; snooper_read_valid = rd; eviction_wren = ev; l1_hold = hold;
        snooper_addr = addr; evictable_cacheline = wd;
    endtask

    initial begin
        //   rst rd ev hold addr        wdata | valid data  busy err rc  ec
        row(0, 1, 0, 0, 32'h5550, '0,   0, '0,  0, 0, 0, 0);      // 0: first cycle after reset
        idle(3, 0,                      0, '0,  1, 0, 1, 0);      // 1-3
        idle(1, 0,                      1, '0,  1, 0, 1, 0);      // 4: unwritten line reads zero
        row(0, 0, 1, 0, 32'h1230, LD,   0, '0,  0, 0, 1, 0);      // 5
        idle(4, 0,                      0, '0,  0, 0, 1, 1);      // 6-9
        row(0, 1, 0, 0, 32'h1230, '0,   0, '0,  0, 0, 1, 1);      // 10
        idle(3, 0,                      0, '0,  1, 0, 2, 1);      // 11-13
        idle(1, 0,                      1, LD,  1, 0, 2, 1);      // 14
        row(0, 0, 1, 0, 32'h0040, LE,   0, '0,  0, 0, 2, 1);      // 15
        row(0, 1, 0, 0, 32'h0040, '0,   0, '0,  0, 0, 2, 2);      // 16
        idle(2, 0,                      0, '0,  1, 0, 3, 2);      // 17-18
        idle(1, 1,                      0, '0,  1, 0, 3, 2);      // 19
        idle(2, 1,                      1, LE,  1, 0, 3, 2);      // 20-21
        row(0, 0, 1, 1, 32'h0040, LF,   1, LE,  1, 0, 3, 2);      // 22: evict during RESPOND
        idle(1, 1,                      1, LE,  1, 0, 3, 3);      // 23
        idle(1, 0,                      1, LE,  1, 0, 3, 3);      // 24: acceptance
        idle(1, 0,                      0, '0,  0, 0, 3, 3);      // 25
        row(0, 1, 0, 0, 32'h0080, '0,   0, '0,  0, 0, 3, 3);      // 26
        idle(2, 0,                      0, '0,  1, 0, 4, 3);      // 27-28
        row(0, 0, 1, 0, 32'h0080, LFF,  0, '0,  1, 0, 4, 3);      // 29: bypass on capture edge
        idle(1, 0,                      1, LFF, 1, 0, 4, 4);      // 30
        idle(1, 0,                      0, '0,  0, 0, 4, 4);      // 31
        row(0, 1, 0, 0, 32'h0010, '0,   0, '0,  0, 0, 4, 4);      // 32
        idle(1, 0,                      0, '0,  1, 0, 5, 4);      // 33
        row(0, 1, 0, 0, 32'h0010, '0,   0, '0,  1, 0, 5, 4);      // 34: read while busy
        idle(1, 0,                      0, '0,  1, 1, 5, 4);      // 35
        idle(1, 0,                      1, '0,  1, 1, 5, 4);      // 36
        idle(1, 0,                      0, '0,  0, 1, 5, 4);      // 37
        row(0, 1, 0, 0, 32'h0040, '0,   0, '0,  0, 1, 5, 4);      // 38
        idle(1, 0,                      0, '0,  1, 1, 6, 4);      // 39
        row(1, 0, 1, 0, 32'h0300, LH,   0, '0,  1, 1, 6, 4);      // 40: reset + evict
        idle(2, 0,                      0, '0,  0, 0, 0, 0);      // 41-42
        row(0, 1, 0, 0, 32'h0040, '0,   0, '0,  0, 0, 0, 0);      // 43
        idle(3, 0,                      0, '0,  1, 0, 1, 0);      // 44-46
        idle(1, 0,                      1, LF,  1, 0, 1, 0);      // 47
        row(0, 1, 0, 0, 32'h0300, '0,   0, '0,  0, 0, 1, 0);      // 48
        idle(3, 0,                      0, '0,  1, 0, 2, 0);      // 49-51
        idle(1, 0,                      1, LH,  1, 0, 2, 0);      // 52
        idle(1, 0,                      0, '0,  0, 0, 2, 0);      // 53
        row(0, 1, 1, 0, 32'h0020, LG,   0, '0,  0, 0, 2, 0);      // 54: read+evict together
        idle(5, 0,                      0, '0,  0, 1, 2, 1);      // 55-59
        row(0, 1, 0, 0, 32'h0020, '0,   0, '0,  0, 1, 2, 1);      // 60
        idle(3, 0,                      0, '0,  1, 1, 3, 1);      // 61-63
        idle(1, 0,                      1, LG,  1, 1, 3, 1);      // 64
        row(0, 1, 0, 0, 32'h1230, '0,   0, '0,  0, 1, 3, 1);      // 65: back-to-back spacing
        idle(3, 0,                      0, '0,  1, 1, 4, 1);      // 66-68
        idle(1, 0,                      1, LD,  1, 1, 4, 1);      // 69
        idle(1, 0,                      0, '0,  0, 1, 4, 1);      // 70

        drive(1, 0, 0, 0, 32'h0, '0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].rd, vecs[i].ev, vecs[i].hold, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            chk(i, "valid", {127'd0, cacheline_update_valid}, {127'd0, vecs[i].exp_valid});
            chk(i, "data",  updated_cacheline, vecs[i].exp_data);
            chk(i, "busy",  {127'd0, busy}, {127'd0, vecs[i].exp_busy});
            chk(i, "error", {127'd0, protocol_error}, {127'd0, vecs[i].exp_err});
            chk(i, "read_count",  {112'd0, read_count},  {112'd0, vecs[i].exp_rc});
            chk(i, "evict_count", {112'd0, evict_count}, {112'd0, vecs[i].exp_ec});
            @(posedge clk);
            #1;
        end

        // Saturation: evict_count starts at 1 here and must stop at 16'hFFFF.
        drive(0, 0, 1, 0, 32'h0500, LH);
        for (int n = 1; n <= 65540; n++) begin
            @(posedge clk);
            #1;
            if (n == 65533) chk(n, "evict_count_pre_sat", {112'd0, evict_count}, {112'd0, 16'hFFFE});
        end
        drive(0, 0, 0, 0, 32'h0, '0);
        @(negedge clk);
        chk(0, "evict_count_sat", {112'd0, evict_count}, {112'd0, 16'hFFFF});
        chk(0, "read_count_after_sat", {112'd0, read_count}, {112'd0, 16'd4});
        chk(0, "busy_after_sat", {127'd0, busy}, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_snoop_responder.md
L2_SNOOP_RESPONDER -- requirements
Module: l2_snoop_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from read acceptance to first cacheline_update_valid; legal range 2..15.
REQ-002 SHALL have parameter IDX_W, default 10: line index width; backing store depth 2**IDX_W lines of 128 bits.
REQ-003 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port snooper_addr, input, 32: line address from L1; index = snooper_addr[IDX_W+3:4]; bits [3:0] ignored.
REQ-006 SHALL have port snooper_read_valid, input, 1: one-cycle line-fill request from L1.
REQ-007 SHALL have port eviction_wren, input, 1: one-cycle write-back strobe from L1.
REQ-008 SHALL have port evictable_cacheline, input, 128: write-back data; word 0 in [31:0], word 3 in [127:96].
REQ-009 SHALL have port l1_hold, input, 1: the attached L1's hotlink_interrupt; when high, L1 cannot accept a fill.
REQ-010 SHALL have port updated_cacheline, output, 128: fill data, same word order as REQ-008.
REQ-011 SHALL have port cacheline_update_valid, output, 1: fill data valid.
REQ-012 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-013 SHALL have port protocol_error, output, 1: sticky illegal-request flag.
REQ-014 SHALL have ports read_count and evict_count, outputs, 16 each: saturating counts of accepted reads and evictions.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESPOND.
REQ-016 In IDLE, snooper_read_valid high with eviction_wren low SHALL accept the read: latch index, go to WAIT, load latency counter.
REQ-017 A read accepted at cycle t SHALL raise cacheline_update_valid first in cycle t+LATENCY (state RESPOND).
REQ-018 Fill data SHALL be the line registered on the WAIT->RESPOND edge, including any eviction to the same index in that same cycle (write-first bypass).
REQ-019 In RESPOND, cacheline_update_valid and updated_cacheline SHALL remain stable while l1_hold is high.
REQ-020 The first RESPOND cycle with l1_hold low SHALL be the acceptance cycle; the next cycle SHALL be IDLE with cacheline_update_valid low.
REQ-021 Minimum spacing between read acceptances SHALL be LATENCY+1 cycles; busy SHALL fall in the cycle after acceptance.
REQ-022 eviction_wren high SHALL write evictable_cacheline to the index in any state, in the same cycle, and increment evict_count.
REQ-023 An eviction to the pending index during WAIT SHALL be visible in the fill data; an eviction during RESPOND SHALL NOT alter the held output.
REQ-024 If snooper_read_valid and eviction_wren are both high, the eviction SHALL win, the read SHALL be dropped, and protocol_error SHALL set.
REQ-025 snooper_read_valid high while busy SHALL be dropped and SHALL set protocol_error; the pending transaction SHALL be unaffected.
REQ-026 read_count SHALL increment once per accepted read; both counters SHALL saturate at 16'hFFFF, with no wrap.
REQ-027 updated_cacheline SHALL be 128'd0 whenever cacheline_update_valid is low.
REQ-028 Backing store SHALL be zero at time 0 and SHALL NOT be cleared by reset.

Reset
REQ-029 reset SHALL force state IDLE, cacheline_update_valid=0, updated_cacheline=0, busy=0, protocol_error=0, read_count=0, evict_count=0.
REQ-030 reset during WAIT or RESPOND SHALL abandon the pending fill; no valid pulse SHALL follow.
REQ-031 An eviction coinciding with reset SHALL still write the backing store.
REQ-032 The first read SHALL be accepted in the cycle after reset deasserts.

Verification
REQ-033 Scenario: evict addr 0x0000_1230, data {32'hD,32'hC,32'hB,32'hA}; read 0x0000_1230 at t=10 with l1_hold=0 -> valid only in cycle 14, data matches, read_count=1, evict_count=1.
REQ-034 Scenario: read 0x40 at t=0, l1_hold high cycles 3..7 -> valid held cycles 4..8 with constant data; IDLE at cycle 9.
REQ-035 Scenario: read 0x80 at t=0, evict 0x80 with 128'hFF at t=3 -> fill at t=4 equals 128'hFF.
REQ-036 Scenario: read 0x10 at t=0, second read at t=2 -> protocol_error=1 from t=3, single valid pulse at t=4, read_count=1.
REQ-037 Scenario: read and evict 0x20 asserted together -> evict written, no fill ever, protocol_error=1.
REQ-038 Scenario: read at t=0, reset at t=2 -> no valid at t=4, all outputs zero; memory contents intact on a later read.
